// File: rtl/leiwand_rv32_mem_arbiter_pkg.sv
// Shared constants for the leiwand_rv32 two-master memory arbiter:
// default bus width and the grant FSM state codes.
package leiwand_rv32_mem_arbiter_pkg;

    localparam int MEM_WIDTH = 32;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_GNT0 = 2'd1;
    localparam logic [1:0] ARB_GNT1 = 2'd2;

    // One-hot owner for a given FSM state; idle and unused codes own nothing.
    function automatic logic [1:0] state_to_grant(input logic [1:0] st);
        logic [1:0] g;
        case (st)
            ARB_GNT0: g = 2'b01;
            ARB_GNT1: g = 2'b10;
            default:  g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/leiwand_rv32_mem_arbiter_pick.sv
// Combinational 2-way request picker. Contention policy is selected by
// LEIWAND_ARB_ROUND_ROBIN_EN (round robin) or fixed M0 priority when undefined.
module leiwand_rv32_arb_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

`ifndef LEIWAND_ARB_ROUND_ROBIN_EN
    logic unused_last_s;
    assign unused_last_s = last;
`endif

    // One-hot choice among the pending requests.
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01: pick = 2'b01;
            2'b10: pick = 2'b10;
            2'b11: begin
`ifdef LEIWAND_ARB_ROUND_ROBIN_EN
                if (last) begin
                    pick = 2'b01;
                end else begin
                    pick = 2'b10;
                end
`else
                pick = 2'b01;
`endif
            end
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/leiwand_rv32_mem_arbiter.sv
// Two-master valid/ready arbiter in front of one memory slave; a grant is held
// for a whole transaction. Contention policy: LEIWAND_ARB_ROUND_ROBIN_EN.
module leiwand_rv32_mem_arbiter
    import leiwand_rv32_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_WIDTH,
    parameter int DATA_W = MEM_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wen,
    output logic [DATA_W-1:0]     m0_rdata,
    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wen,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  s_valid,
    input  logic                  s_ready,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wen,
    input  logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            grant
);

    logic [1:0] state_r;
    logic [1:0] next_state_s;
    logic       last_grant_r;
    logic       next_last_s;
    logic [1:0] pick_s;

    leiwand_rv32_arb_pick u_pick (
        .req  ({m1_valid, m0_valid}),
        .last (last_grant_r),
        .pick (pick_s)
    );

    // Next-state logic: a completion (s_ready) wins over a dropped valid.
    always_comb begin
        next_state_s = state_r;
        next_last_s  = last_grant_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_s[0]) begin
                    next_state_s = ARB_GNT0;
                end else if (pick_s[1]) begin
                    next_state_s = ARB_GNT1;
                end else begin
                    next_state_s = ARB_IDLE;
                end
            end
            ARB_GNT0: begin
                if (s_ready) begin
                    next_state_s = ARB_IDLE;
                    next_last_s  = 1'b0;
                end else if (!m0_valid) begin
                    next_state_s = ARB_IDLE;
                end else begin
                    next_state_s = ARB_GNT0;
                end
            end
            ARB_GNT1: begin
                if (s_ready) begin
                    next_state_s = ARB_IDLE;
                    next_last_s  = 1'b1;
                end else if (!m1_valid) begin
                    next_state_s = ARB_IDLE;
                end else begin
                    next_state_s = ARB_GNT1;
                end
            end
            default: begin
                next_state_s = ARB_IDLE;
                next_last_s  = last_grant_r;
            end
        endcase
    end

    // State and last-owner registers; last owner resets to M1 so M0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ARB_IDLE;
            last_grant_r <= 1'b1;
        end else begin
            state_r      <= next_state_s;
            last_grant_r <= next_last_s;
        end
    end

    // Slave-side mux: only the owner reaches the slave, everything else reads 0.
    always_comb begin
        s_valid  = 1'b0;
        s_addr   = {ADDR_W{1'b0}};
        s_wdata  = {DATA_W{1'b0}};
        s_wen    = {(DATA_W/8){1'b0}};
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        case (state_r)
            ARB_GNT0: begin
                s_valid  = m0_valid;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wen    = m0_wen;
                m0_ready = s_ready;
            end
            ARB_GNT1: begin
                s_valid  = m1_valid;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wen    = m1_wen;
                m1_ready = s_ready;
            end
            default: begin
                s_valid  = 1'b0;
                m0_ready = 1'b0;
                m1_ready = 1'b0;
            end
        endcase
    end

    assign grant    = state_to_grant(state_r);
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_leiwand_rv32_mem_arbiter.sv
// Scoreboard bench for leiwand_rv32_mem_arbiter with a simple_mem-like slave
// model; expected order follows LEIWAND_ARB_ROUND_ROBIN_EN.
module tb_leiwand_rv32_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0;
    logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h0;
    logic [3:0]  m0_wen = 4'h0, m1_wen = 4'h0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wen;
    logic [1:0]  grant;
    logic        slave_stall = 1'b0;
    logic [31:0] mem [0:63];

    typedef struct {
        logic [1:0]  who;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
        logic [31:0] rdata;
        bit          chk_rdata;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    leiwand_rv32_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wen(m0_wen), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wen(m1_wen), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wen(s_wen), .s_rdata(s_rdata),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model: ready one cycle after valid, byte-masked write on that edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s_ready  <= 1'b0;
            s_rdata  <= 32'h0;
            mem[4]   <= 32'hDEADBEEF;
            mem[8]   <= 32'h11112222;
            mem[16]  <= 32'hAAAAAAAA;
        end else if (s_valid && !s_ready && !slave_stall) begin
            s_ready <= 1'b1;
            s_rdata <= mem[s_addr[7:2]];
            for (int b = 0; b < 4; b++) begin
                if (s_wen[b]) mem[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            end
        end else begin
            s_ready <= 1'b0;
        end
    end

    // Monitor: every ready pulse must match the oldest expected transaction.
    always @(negedge clk) begin
        if (m0_ready || m1_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: ready=%b with nothing pending at %0t",
                         {m1_ready, m0_ready}, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ready_owner", {30'h0, m1_ready, m0_ready}, {30'h0, e.who});
                chk("ready_with_s_ready", {31'h0, s_ready}, 32'h1);
                chk("grant_owner", {30'h0, grant}, {30'h0, e.who});
                chk("s_addr", s_addr, e.addr);
                chk("s_wdata", s_wdata, e.wdata);
                chk("s_wen", {28'h0, s_wen}, {28'h0, e.wen});
                if (e.chk_rdata) chk("rdata", e.who[1] ? m1_rdata : m0_rdata, e.rdata);
            end
        end
    end

    task automatic wait_ready(input logic [1:0] mask, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (({m1_ready, m0_ready} & mask) != 2'b00) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_timeout: ready not seen within 30 cycles", tag);
        end
    endtask

    task automatic wait_grant(input logic [1:0] g, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (grant == g) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_timeout: grant %b not seen within 30 cycles", tag, g);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] who, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wen,
                                input logic [31:0] rdata, input bit chk_rd);
        exp_t e;
        e.who = who; e.addr = addr; e.wdata = wdata; e.wen = wen;
        e.rdata = rdata; e.chk_rdata = chk_rd;
        return e;
    endfunction

    initial begin
        // Reset held with both masters requesting.
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_valid", {31'h0, s_valid}, 32'h0);
        chk("rst_grant", {30'h0, grant}, 32'h0);
        chk("rst_m0_ready", {31'h0, m0_ready}, 32'h0);
        chk("rst_m1_ready", {31'h0, m1_ready}, 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        reset = 1'b0;

        // Single read by M0.
        @(posedge clk); #1;
        m0_addr = 32'h10; m0_wen = 4'h0; m0_wdata = 32'h0; m0_valid = 1'b1;
        sb.push_back(mk(2'b01, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1));
        @(negedge clk);
        chk("idle_no_comb_path", {31'h0, s_valid}, 32'h0);
        @(negedge clk);
        chk("s_valid_latency", {31'h0, s_valid}, 32'h1);
        chk("grant_m0", {30'h0, grant}, 32'h1);
        wait_ready(2'b01, "rd");
        @(posedge clk); #1 m0_valid = 1'b0;

        // Write by M1, low half only.
        @(posedge clk); #1;
        m1_addr = 32'h40; m1_wdata = 32'h12345678; m1_wen = 4'b0011; m1_valid = 1'b1;
        sb.push_back(mk(2'b10, 32'h40, 32'h12345678, 4'b0011, 32'h0, 1'b0));
        wait_ready(2'b10, "wr");
        @(posedge clk); #1 m1_valid = 1'b0;
        chk("mem_low_half", mem[16], 32'hAAAA5678);

        // Contention: both request continuously for four transactions.
        m0_addr = 32'h10; m0_wen = 4'h0; m0_wdata = 32'h0;
        m1_addr = 32'h20; m1_wen = 4'h0; m1_wdata = 32'h0;
        m0_valid = 1'b1;
        m1_valid = 1'b1;
`ifdef LEIWAND_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 2; k++) begin
            sb.push_back(mk(2'b01, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1));
            sb.push_back(mk(2'b10, 32'h20, 32'h0, 4'h0, 32'h11112222, 1'b1));
        end
`else
        for (int k = 0; k < 4; k++) begin
            sb.push_back(mk(2'b01, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1));
        end
`endif
        for (int i = 0; i < 4; i++) begin
            wait_ready(2'b11, "cont");
            @(posedge clk); #1;
            if (i == 3) begin
                m0_valid = 1'b0;
                m1_valid = 1'b0;
            end
            @(negedge clk);
            chk("bubble_s_valid", {31'h0, s_valid}, 32'h0);
            chk("bubble_grant", {30'h0, grant}, 32'h0);
        end

        // Reset in the middle of a stalled M1 transaction.
        @(posedge clk); #1;
        slave_stall = 1'b1;
        m1_addr = 32'h20; m1_valid = 1'b1;
        wait_grant(2'b10, "midrst");
        @(posedge clk); #2 reset = 1'b1;
        #1;
        chk("midrst_s_valid", {31'h0, s_valid}, 32'h0);
        chk("midrst_grant", {30'h0, grant}, 32'h0);
        chk("midrst_m1_ready", {31'h0, m1_ready}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        slave_stall = 1'b0;
        sb.push_back(mk(2'b10, 32'h20, 32'h0, 4'h0, 32'h11112222, 1'b1));
        wait_ready(2'b10, "postrst");
        @(posedge clk); #1 m1_valid = 1'b0;

        // M0 drops valid while granted; M1 must be served next.
        @(posedge clk); #1;
        slave_stall = 1'b1;
        m0_addr = 32'h10; m0_valid = 1'b1;
        m1_addr = 32'h20; m1_valid = 1'b1;
        wait_grant(2'b01, "drop");
        m0_valid = 1'b0;
        #1 chk("drop_s_valid_follows", {31'h0, s_valid}, 32'h0);
        @(negedge clk);
        chk("drop_idle", {30'h0, grant}, 32'h0);
        @(negedge clk);
        chk("drop_m1_grant", {30'h0, grant}, 32'h2);
        slave_stall = 1'b0;
        sb.push_back(mk(2'b10, 32'h20, 32'h0, 4'h0, 32'h11112222, 1'b1));
        wait_ready(2'b10, "drop_m1");
        @(posedge clk); #1 m1_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
